ref_clk_training_ctrl: RTL and testbench
========================================

Name: ref_clk_training_ctrl

Overview:
- Fabric-side controller for the DDR3 PHY reference-clock training lane.
- Drives the lane's input delay line through its LOAD, MOVE and DIRECTION controls, and clears the eye-monitor flags.
- Reads the 8-bit deserialized reference-clock samples and sweeps the delay until the sampled clock pattern changes, which marks the clock edge.
- Reports the tap count at the edge, plus done and fail status, to the PHY training sequencer.

Parameters:
- SETTLE_CYCLES, 8: FAB_CLK cycles to wait after any delay-line LOAD or MOVE before sampling RX_DATA (range 1..255).
- CONFIRM_CNT, 4: consecutive mismatching samples required to declare the edge (range 1..15).
- MAX_TAPS, 127: maximum MOVE steps before training fails (range 1..255).

Ports:
- FAB_CLK, in, 1: fabric clock; all logic is on its rising edge.
- RESET, in, 1: synchronous, active-high reset.
- START, in, 1: single-cycle request to begin training. Accepted in IDLE, DONE or FAIL; ignored otherwise.
- RX_DATA_0, in, 8: deserialized reference-clock samples from the lane.
- EYE_MONITOR_EARLY_0, in, 1: eye-monitor early flag from the lane.
- EYE_MONITOR_LATE_0, in, 1: eye-monitor late flag from the lane.
- DELAY_LINE_OUT_OF_RANGE_0, in, 1: delay line has hit its end stop.
- DELAY_LINE_LOAD_0, out, 1: one-cycle pulse that reloads the delay line to its static value.
- DELAY_LINE_MOVE_0, out, 1: one-cycle pulse that steps the delay line by one tap.
- DELAY_LINE_DIRECTION_0, out, 1: step direction, 1 = increment. Held at 1 from LOAD until DONE or FAIL; 0 otherwise.
- EYE_MONITOR_CLEAR_FLAGS_0, out, 1: one-cycle pulse, coincident with LOAD.
- BUSY, out, 1: high in every state except IDLE, DONE and FAIL.
- TRAIN_DONE, out, 1: level; edge found.
- TRAIN_FAIL, out, 1: level; training aborted.
- TAP_COUNT, out, 8: number of MOVE pulses issued in the current run.
- EYE_STATUS, out, 2: {EARLY, LATE} sticky-ORed from the cycle after LOAD until DONE or FAIL, then frozen.

Behaviour:
- Reset: state goes to IDLE. Every output is 0, including TAP_COUNT and EYE_STATUS, and all internal counters and the reference register are cleared. Reset asserted mid-run aborts the run the same way; no further LOAD or MOVE pulse is issued.
- IDLE: on START=1, go to LOAD on the next edge.
- LOAD (1 cycle):
  - Assert LOAD, CLEAR_FLAGS and DIRECTION.
  - Clear TAP_COUNT, EYE_STATUS and the confirm counter.
  - Go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to REF.
- REF (1 cycle): capture ref <= RX_DATA_0, then go to MOVE.
- MOVE (1 cycle):
  - Assert MOVE and increment TAP_COUNT; TAP_COUNT reads the new value in the following cycle.
  - Go to WAIT.
- WAIT: count SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (1 cycle per sample):
  - RX_DATA_0 != ref: increment the confirm counter. If the new value equals CONFIRM_CNT, go to DONE; otherwise stay in CHECK and sample again next cycle.
  - RX_DATA_0 == ref: clear the confirm counter. If TAP_COUNT == MAX_TAPS, go to FAIL; otherwise go to MOVE.
- OUT_OF_RANGE: if DELAY_LINE_OUT_OF_RANGE_0=1 in MOVE, WAIT or CHECK, go to FAIL next cycle. It takes priority over an edge decision in the same cycle. It is ignored in LOAD, SETTLE and REF.
- DONE and FAIL:
  - TRAIN_DONE or TRAIN_FAIL is held high; TAP_COUNT and EYE_STATUS are held.
  - START restarts the run: the state goes to LOAD and TRAIN_DONE/TRAIN_FAIL clear in the same edge.
- Pulse rules: LOAD and MOVE are never high in the same cycle. Minimum spacing between MOVE pulses is SETTLE_CYCLES+2 cycles.
- Latency: with no mismatches, one step costs SETTLE_CYCLES+2 cycles. START to the first MOVE is SETTLE_CYCLES+3 cycles.
- TAP_COUNT never wraps, because MAX_TAPS ≤ 255.

Test Plan:
1. Defaults. RX_DATA=0xF0 until after the 10th MOVE, 0x0F from then on. START → TRAIN_DONE with TAP_COUNT=10. Exactly one LOAD pulse and 10 MOVE pulses. TRAIN_DONE rises 4 CHECK cycles after the 10th WAIT.
2. Glitch rejection. After MOVE 5, mismatch on 2 samples then a match; the real change comes after MOVE 12. Required: TRAIN_DONE with TAP_COUNT=12.
3. Sweep exhaustion. MAX_TAPS=20, RX_DATA constant 0xCC → TRAIN_FAIL after 20 MOVE pulses, TAP_COUNT=20, no 21st MOVE.
4. End stop. OUT_OF_RANGE asserted during WAIT after MOVE 7 → TRAIN_FAIL with TAP_COUNT=7. It wins even if the mismatch confirm completes in the same cycle.
5. Reset mid-sweep. RESET pulsed during WAIT after MOVE 3 → all outputs 0 and state IDLE. A new START then produces LOAD and restarts with TAP_COUNT=0.
6. Eye flags and restart. EARLY pulsed once mid-sweep → EYE_STATUS=2'b10 held in DONE. START in DONE clears TRAIN_DONE and EYE_STATUS and pulses LOAD together with CLEAR_FLAGS.

Source files
------------

// File: rtl/ref_clk_training_ctrl.sv
// ref_clk_training_ctrl: sweeps the ref-clock lane delay line until the sampled clock pattern changes.
module ref_clk_training_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int CONFIRM_CNT = 4,
  parameter int MAX_TAPS = 127
) (
  input  logic       FAB_CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] RX_DATA_0,
  input  logic       EYE_MONITOR_EARLY_0,
  input  logic       EYE_MONITOR_LATE_0,
  input  logic       DELAY_LINE_OUT_OF_RANGE_0,
  output logic       DELAY_LINE_LOAD_0,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  output logic       EYE_MONITOR_CLEAR_FLAGS_0,
  output logic       BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_FAIL,
  output logic [7:0] TAP_COUNT,
  output logic [1:0] EYE_STATUS
);
  typedef enum logic [3:0] {IDLE, LOAD, SETTLE, REF, MOVE, WAIT, CHECK, DONE, FAIL} state_e;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] MAX_T = 8'(MAX_TAPS);
  localparam logic [3:0] CONF_LAST = 4'(CONFIRM_CNT - 1);
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d, tap_q, tap_d, ref_q, ref_d;
  logic [3:0] conf_q, conf_d;
  logic [1:0] eye_q, eye_d;
  logic busy, oor, mismatch;
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tap_q <= '0;
      ref_q <= '0;
      conf_q <= '0;
      eye_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tap_q <= tap_d;
      ref_q <= ref_d;
      conf_q <= conf_d;
      eye_q <= eye_d;
    end
  end
  always_comb begin
    busy = state_q inside {LOAD, SETTLE, REF, MOVE, WAIT, CHECK};
    oor = DELAY_LINE_OUT_OF_RANGE_0 && (state_q inside {MOVE, WAIT, CHECK});
    mismatch = RX_DATA_0 != ref_q;
    state_d = state_q;
    cnt_d = cnt_q;
    tap_d = tap_q;
    ref_d = ref_q;
    conf_d = conf_q;
    eye_d = (busy && state_q != LOAD) ? eye_q | {EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0} : eye_q;
    case (state_q)
      IDLE, DONE, FAIL: state_d = START ? LOAD : state_q;
      LOAD: begin
        state_d = SETTLE;
        cnt_d = '0;
        tap_d = '0;
        conf_d = '0;
        eye_d = '0;
      end
      SETTLE, WAIT: begin
        cnt_d = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 8'd1;
        state_d = (cnt_q != SETTLE_LAST) ? state_q : (state_q == SETTLE) ? REF : CHECK;
      end
      REF: begin
        ref_d = RX_DATA_0;
        state_d = MOVE;
      end
      MOVE: begin
        tap_d = tap_q + 8'd1;
        state_d = WAIT;
      end
      CHECK: begin
        conf_d = mismatch ? conf_q + 4'd1 : '0;
        state_d = mismatch ? ((conf_q == CONF_LAST) ? DONE : CHECK) : ((tap_q == MAX_T) ? FAIL : MOVE);
      end
      default: state_d = IDLE;
    endcase
    // end stop overrides any edge or exhaustion decision taken this cycle
    if (oor) state_d = FAIL;
  end
  assign DELAY_LINE_LOAD_0 = state_q == LOAD;
  assign EYE_MONITOR_CLEAR_FLAGS_0 = state_q == LOAD;
  assign DELAY_LINE_MOVE_0 = state_q == MOVE;
  assign DELAY_LINE_DIRECTION_0 = busy;
  assign BUSY = busy;
  assign TRAIN_DONE = state_q == DONE;
  assign TRAIN_FAIL = state_q == FAIL;
  assign TAP_COUNT = tap_q;
  assign EYE_STATUS = eye_q;
endmodule

// File: tb/tb_ref_clk_training_ctrl.sv
// tb_ref_clk_training_ctrl: table-driven and randomized checks against a timeline model of the training sweep.
module tb_ref_clk_training_ctrl;
  localparam int S = 8;
  localparam int C = 4;
  localparam int NC = 4096;
  typedef struct {
    bit sel;
    int edge_t;
    int g_tap;
    int g_n;
    int oor_tap;
    int oor_off;
    int ea_c;
    int la_c;
    logic [7:0] rx_a;
    logic [7:0] rx_b;
    int exp_tap;
    bit exp_done;
    logic [1:0] exp_eye;
  } vec_t;
  logic clk = 0;
  logic rst, start, early, late, oor;
  logic [7:0] rx;
  logic ld0, cl0, mv0, dr0, bz0, dn0, fl0, ld1, cl1, mv1, dr1, bz1, dn1, fl1;
  logic [7:0] tap0, tap1;
  logic [1:0] eye0, eye1;
  int n_cmp = 0;
  int n_err = 0;
  int maxt, edge_t, oor_tap, oor_off, fin, r_tap, st_noise;
  bit r_done, cur_sel;
  logic [7:0] rx_a, rx_b;
  int gl[256];
  bit mv_e[NC];
  bit oor_p[NC];
  bit ea_p[NC];
  bit la_p[NC];
  logic [7:0] rx_p[NC];
  vec_t tv[7];
  always #5 clk = ~clk;
  ref_clk_training_ctrl u_dut0 (
    .FAB_CLK(clk), .RESET(rst), .START(start), .RX_DATA_0(rx),
    .EYE_MONITOR_EARLY_0(early), .EYE_MONITOR_LATE_0(late), .DELAY_LINE_OUT_OF_RANGE_0(oor),
    .DELAY_LINE_LOAD_0(ld0), .DELAY_LINE_MOVE_0(mv0), .DELAY_LINE_DIRECTION_0(dr0),
    .EYE_MONITOR_CLEAR_FLAGS_0(cl0), .BUSY(bz0), .TRAIN_DONE(dn0), .TRAIN_FAIL(fl0),
    .TAP_COUNT(tap0), .EYE_STATUS(eye0));
  ref_clk_training_ctrl #(.MAX_TAPS(20)) u_dut1 (
    .FAB_CLK(clk), .RESET(rst), .START(start), .RX_DATA_0(rx),
    .EYE_MONITOR_EARLY_0(early), .EYE_MONITOR_LATE_0(late), .DELAY_LINE_OUT_OF_RANGE_0(oor),
    .DELAY_LINE_LOAD_0(ld1), .DELAY_LINE_MOVE_0(mv1), .DELAY_LINE_DIRECTION_0(dr1),
    .EYE_MONITOR_CLEAR_FLAGS_0(cl1), .BUSY(bz1), .TRAIN_DONE(dn1), .TRAIN_FAIL(fl1),
    .TAP_COUNT(tap1), .EYE_STATUS(eye1));
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic setup();
    for (int i = 0; i < 256; i++) gl[i] = 0;
    for (int i = 0; i < NC; i++) begin
      ea_p[i] = 0;
      la_p[i] = 0;
    end
    st_noise = -1;
    oor_tap = 0;
    oor_off = 0;
  endtask
  // Cycle 0 carries START; builds the expected MOVE timeline, RX_DATA plan and outcome.
  task automatic plan();
    int t, cs, n, k, last;
    bit stop;
    for (int i = 0; i < NC; i++) begin
      mv_e[i] = 0;
      rx_p[i] = rx_a;
      oor_p[i] = 0;
    end
    t = S + 3;
    k = 0;
    stop = 0;
    while (!stop) begin
      k++;
      mv_e[t] = 1;
      cs = t + 1 + S;
      n = (edge_t != 0 && k >= edge_t) ? C : gl[k];
      last = (n == C) ? cs + C - 1 : cs + n;
      for (int i = cs; i < cs + n; i++) rx_p[i] = rx_b;
      if (oor_tap == k && t + oor_off <= last) begin
        oor_p[t + oor_off] = 1;
        fin = t + oor_off + 1;
        r_done = 0;
        r_tap = k;
        stop = 1;
      end else if (n == C) begin
        fin = cs + C;
        r_done = 1;
        r_tap = k;
        stop = 1;
      end else if (k == maxt) begin
        fin = last + 1;
        r_done = 0;
        r_tap = k;
        stop = 1;
      end else t = last + 1;
    end
  endtask
  task automatic run(bit sel, int rst_c);
    logic [6:0] got, ex;
    logic [7:0] tg;
    logic [1:0] eg, ey;
    int mc;
    bit bz;
    mc = 0;
    ey = 0;
    for (int c = 0; c <= fin + 3; c++) begin
      start = (c == 0) || (c == st_noise && c < fin);
      rx = rx_p[c];
      oor = oor_p[c];
      early = ea_p[c];
      late = la_p[c];
      rst = (c == rst_c);
      if (c >= 1) begin
        mc += int'(mv_e[c-1]);
        if (c - 1 >= 2 && c - 1 < fin) ey |= {ea_p[c-1], la_p[c-1]};
      end
      @(negedge clk);
      got = sel ? {ld1, cl1, mv1, dr1, bz1, dn1, fl1} : {ld0, cl0, mv0, dr0, bz0, dn0, fl0};
      tg = sel ? tap1 : tap0;
      eg = sel ? eye1 : eye0;
      bz = c >= 1 && c < fin;
      ex = {c == 1, c == 1, mv_e[c], bz, bz, c >= fin && r_done, c >= fin && !r_done};
      if (c >= 1) chk("ctl{ld,clr,mv,dir,busy,done,fail}", 32'(got), 32'(ex));
      if (c >= 2) begin
        chk("tap_count", 32'(tg), mc);
        chk("eye_status", 32'(eg), 32'(ey));
      end
      @(posedge clk);
      #1;
      if (c == rst_c) break;
    end
    {rst, start, oor, early, late} = '0;
  endtask
  task automatic check_zero(string nm);
    @(negedge clk);
    chk(nm, {ld0, cl0, mv0, dr0, bz0, dn0, fl0, tap0, eye0, ld1, cl1, mv1, dr1, bz1, dn1, fl1, tap1, eye1}, 0);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    {rst, start, oor, early, late} = '0;
    rx = 0;
    #1;
    do_reset();
    check_zero("reset_state");
    cur_sel = 0;
    tv[0] = '{0, 10, 0, 0, 0, 0, -1, -1, 8'hF0, 8'h0F, 10, 1, 2'b00};
    tv[1] = '{0, 12, 5, 2, 0, 0, -1, -1, 8'hF0, 8'h0F, 12, 1, 2'b00};
    tv[2] = '{1, 0, 0, 0, 0, 0, -1, -1, 8'hCC, 8'h33, 20, 0, 2'b00};
    tv[3] = '{0, 0, 0, 0, 7, 3, -1, -1, 8'hAA, 8'h55, 7, 0, 2'b00};
    tv[4] = '{0, 7, 0, 0, 7, 12, -1, -1, 8'hAA, 8'h55, 7, 0, 2'b00};
    tv[5] = '{0, 8, 0, 0, 0, 0, 30, -1, 8'h3C, 8'hC3, 8, 1, 2'b10};
    tv[6] = '{0, 3, 0, 0, 0, 0, -1, 20, 8'h81, 8'h18, 3, 1, 2'b01};
    for (int i = 0; i < 7; i++) begin
      if (tv[i].sel != cur_sel) begin
        do_reset();
        cur_sel = tv[i].sel;
      end
      setup();
      edge_t = tv[i].edge_t;
      gl[tv[i].g_tap] = tv[i].g_n;
      oor_tap = tv[i].oor_tap;
      oor_off = tv[i].oor_off;
      if (tv[i].ea_c >= 0) ea_p[tv[i].ea_c] = 1;
      if (tv[i].la_c >= 0) la_p[tv[i].la_c] = 1;
      rx_a = tv[i].rx_a;
      rx_b = tv[i].rx_b;
      maxt = tv[i].sel ? 20 : 127;
      plan();
      run(tv[i].sel, -1);
      @(negedge clk);
      chk("vec_tap", 32'(tv[i].sel ? tap1 : tap0), tv[i].exp_tap);
      chk("vec_result", 32'(tv[i].sel ? {dn1, fl1} : {dn0, fl0}), {tv[i].exp_done, !tv[i].exp_done});
      chk("vec_eye", 32'(tv[i].sel ? eye1 : eye0), 32'(tv[i].exp_eye));
      @(posedge clk);
      #1;
    end
    if (cur_sel) do_reset();
    setup();
    edge_t = 0;
    rx_a = 8'h5A;
    maxt = 127;
    plan();
    run(0, 33);
    check_zero("reset_midrun");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_no_pulse", {ld0, mv0, bz0}, 0);
      @(posedge clk);
      #1;
    end
    setup();
    edge_t = 2;
    rx_b = 8'hA5;
    plan();
    run(0, -1);
    for (int it = 0; it < 20; it++) begin
      setup();
      edge_t = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 30);
      for (int k = 1; k < 30; k++) if ($urandom_range(0, 3) == 0) gl[k] = $urandom_range(1, C - 1);
      if ($urandom_range(0, 4) == 0) begin
        oor_tap = $urandom_range(1, 30);
        oor_off = $urandom_range(0, S + 1);
      end
      for (int c = 0; c < NC; c++) begin
        ea_p[c] = $urandom_range(0, 79) == 0;
        la_p[c] = $urandom_range(0, 79) == 0;
      end
      rx_a = 8'($urandom);
      rx_b = rx_a ^ 8'($urandom_range(1, 255));
      st_noise = $urandom_range(2, 12);
      plan();
      if ($urandom_range(0, 1) == 1) oor_p[$urandom_range(1, S + 2)] = 1;
      run(0, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
